// File: rtl/uart_rx_pkg.sv
// UART receiver shared definitions: state encoding and datapath widths.
package uart_rx_pkg;

  // Same encoding as the matching transmitter
  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    RX_START_BIT = 3'b001,
    RX_DATA_BITS = 3'b010,
    RX_STOP_BIT  = 3'b011,
    CLEANUP      = 3'b100
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver next-state logic plus the N-bit equality comparator used
// to decode the current state.
module Comparator_N_bits #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  output logic         o_Eq
);

  // Bitwise equality reduced to a single match flag
  always_comb begin
    o_Eq = &(~(i_A ^ i_B));
  end

endmodule

module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic             i_Clock,
  input  logic             i_Enable,
  input  logic             i_Rx_Line,
  input  state_t           i_Current_State,
  input  logic [CNT_W-1:0] i_Clock_Count,
  input  logic [IDX_W-1:0] i_Bit_Index,
  output state_t           o_Next_State
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic is_idle;
  logic is_start;
  logic is_data;
  logic is_stop;
  logic is_cleanup;
  logic at_mid;
  logic at_last;
  logic last_bit;

  Comparator_N_bits #(.N(3)) u_cmp_idle (
    .i_A(i_Current_State), .i_B(IDLE), .o_Eq(is_idle)
  );
  Comparator_N_bits #(.N(3)) u_cmp_start (
    .i_A(i_Current_State), .i_B(RX_START_BIT), .o_Eq(is_start)
  );
  Comparator_N_bits #(.N(3)) u_cmp_data (
    .i_A(i_Current_State), .i_B(RX_DATA_BITS), .o_Eq(is_data)
  );
  Comparator_N_bits #(.N(3)) u_cmp_stop (
    .i_A(i_Current_State), .i_B(RX_STOP_BIT), .o_Eq(is_stop)
  );
  Comparator_N_bits #(.N(3)) u_cmp_cleanup (
    .i_A(i_Current_State), .i_B(CLEANUP), .o_Eq(is_cleanup)
  );

  // Counter/index milestones that drive the transitions
  always_comb begin
    at_mid   = (i_Clock_Count == MID_CNT);
    at_last  = (i_Clock_Count == LAST_CNT);
    last_bit = (i_Bit_Index == IDX_W'(7));
  end

  // Next-state selection; disable forces IDLE from any state
  always_comb begin
    o_Next_State = i_Current_State;
    if (!i_Enable) begin
      o_Next_State = IDLE;
    end else if (is_idle) begin
      if (!i_Rx_Line) o_Next_State = RX_START_BIT;
    end else if (is_start) begin
      if (at_mid) o_Next_State = i_Rx_Line ? IDLE : RX_DATA_BITS;
    end else if (is_data) begin
      if (at_last && last_bit) o_Next_State = RX_STOP_BIT;
    end else if (is_stop) begin
      if (at_last) o_Next_State = CLEANUP;
    end else if (is_cleanup) begin
      o_Next_State = IDLE;
    end else begin
      o_Next_State = IDLE;
    end
  end

  // Bit timer must never run past the last cycle of a bit
  a_count_bounded: assert property (@(posedge i_Clock) i_Clock_Count <= LAST_CNT);

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver, LSB first, idle-high line.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer ahead of the
// line sampling flop (adds 2 cycles of detection latency).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy,
  output logic       o_Frame_Err
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clock_count_q, clock_count_d;
  logic [IDX_W-1:0] bit_index_q, bit_index_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_q, rx_d;
  logic             line_in;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Two-stage shift toward the sampling flop
  always_comb begin
    sync_d = {sync_q[0], i_Rx_Serial};
  end

  // Synchronizer flops idle high like the line
  always_ff @(posedge i_Clock) begin
    if (i_Reset) sync_q <= '1;
    else         sync_q <= sync_d;
  end

  always_comb begin
    line_in = sync_q[1];
  end
`else
  // Line feeds the sampling flop directly
  always_comb begin
    line_in = i_Rx_Serial;
  end
`endif

  // Sampling flop input
  always_comb begin
    rx_d = line_in;
  end

  // Registered line sample, idle high after reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) rx_q <= 1'b1;
    else         rx_q <= rx_d;
  end

  uart_rx_fsm #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_fsm (
    .i_Clock        (i_Clock),
    .i_Enable       (i_Enable),
    .i_Rx_Line      (rx_q),
    .i_Current_State(state_q),
    .i_Clock_Count  (clock_count_q),
    .i_Bit_Index    (bit_index_q),
    .o_Next_State   (state_d)
  );

  // State register; reset overrides every transition
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Bit timer, bit index, shift register and one-cycle result pulses
  always_comb begin
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    rx_byte_d     = rx_byte_q;
    rx_dv_d       = 1'b0;
    frame_err_d   = 1'b0;
    if (!i_Enable) begin
      clock_count_d = '0;
      bit_index_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          clock_count_d = '0;
          bit_index_d   = '0;
        end
        RX_START_BIT: begin
          if (clock_count_q == MID_CNT) begin
            clock_count_d = '0;
            bit_index_d   = '0;
          end else begin
            clock_count_d = clock_count_q + CNT_W'(1);
          end
        end
        RX_DATA_BITS: begin
          if (clock_count_q == LAST_CNT) begin
            clock_count_d          = '0;
            rx_byte_d[bit_index_q] = rx_q;
            // index 7 wraps to 0 as the frame moves to the stop bit
            bit_index_d            = bit_index_q + IDX_W'(1);
          end else begin
            clock_count_d = clock_count_q + CNT_W'(1);
          end
        end
        RX_STOP_BIT: begin
          if (clock_count_q == LAST_CNT) begin
            clock_count_d = '0;
            rx_dv_d       = rx_q;
            frame_err_d   = ~rx_q;
          end else begin
            clock_count_d = clock_count_q + CNT_W'(1);
          end
        end
        default: begin
          clock_count_d = '0;
          bit_index_d   = '0;
        end
      endcase
    end
  end

  // Datapath registers; pulses land in the CLEANUP cycle
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      clock_count_q <= '0;
      bit_index_q   <= '0;
      rx_byte_q     <= '0;
      rx_dv_q       <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      rx_byte_q     <= rx_byte_d;
      rx_dv_q       <= rx_dv_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Output decode
  always_comb begin
    o_Rx_Busy   = (state_q != IDLE);
    o_Rx_DV     = rx_dv_q;
    o_Frame_Err = frame_err_q;
    o_Rx_Byte   = rx_byte_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  // Negedges from driving the start edge until busy is observed high:
  // one to register the line, one to change state, one to the sample point.
`ifdef UART_RX_SYNC_EN
  localparam int DET_LAT = 5;
`else
  localparam int DET_LAT = 3;
`endif
  // START(8) + DATA(8*16) + STOP(16) + CLEANUP(1)
  localparam int BUSY_LEN = 153;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx;
  logic       dv;
  logic [7:0] byte_o;
  logic       busy;
  logic       fe;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Enable   (en),
    .i_Rx_Serial(rx),
    .o_Rx_DV    (dv),
    .o_Rx_Byte  (byte_o),
    .o_Rx_Busy  (busy),
    .o_Frame_Err(fe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         start_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] dv_bytes [64];
  int         dv_cycs [64];

  // Observer on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dv) begin
      if (dv_cnt < 64) begin
        dv_bytes[dv_cnt] = byte_o;
        dv_cycs[dv_cnt]  = cyc;
      end
      dv_cnt = dv_cnt + 1;
    end
    if (fe) fe_cnt = fe_cnt + 1;
    if (dv && fe) both_cnt = both_cnt + 1;
    if (busy && !busy_prev) rise_cyc = cyc;
    if (!busy && busy_prev) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_o !== 8'h00) begin failures++; $display("FAIL rst_byte got=%h exp=00", byte_o); end
    checks++; if (dv !== 1'b0) begin failures++; $display("FAIL rst_dv got=%b exp=0", dv); end
    checks++; if (fe !== 1'b0) begin failures++; $display("FAIL rst_fe got=%b exp=0", fe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single_byte;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL a5_dv_count got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (dv_bytes[dv0] !== 8'hA5) begin failures++; $display("FAIL a5_byte_at_dv got=%h exp=a5", dv_bytes[dv0]); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL a5_fe_count got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (rise_cyc - start_cyc !== DET_LAT) begin failures++; $display("FAIL a5_detect_latency got=%0d exp=%0d", rise_cyc - start_cyc, DET_LAT); end
    checks++; if (fall_cyc - rise_cyc !== BUSY_LEN) begin failures++; $display("FAIL a5_busy_len got=%0d exp=%0d", fall_cyc - rise_cyc, BUSY_LEN); end
    checks++; if (dv_cycs[dv0] !== fall_cyc - 1) begin failures++; $display("FAIL a5_dv_in_cleanup got=%0d exp=%0d", dv_cycs[dv0], fall_cyc - 1); end
  endtask

  task automatic test_back_to_back;
    int dv0;
    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 2) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt - dv0); end
    checks++; if (dv_bytes[dv0] !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", dv_bytes[dv0]); end
    checks++; if (dv_bytes[dv0+1] !== 8'hFF) begin failures++; $display("FAIL b2b_second got=%h exp=ff", dv_bytes[dv0+1]); end
    checks++; if (dv_cycs[dv0+1] - dv_cycs[dv0] !== 160) begin failures++; $display("FAIL b2b_spacing got=%0d exp=160", dv_cycs[dv0+1] - dv_cycs[dv0]); end
    checks++; if (byte_o !== 8'hFF) begin failures++; $display("FAIL b2b_hold got=%h exp=ff", byte_o); end
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    start_cyc = cyc;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    checks++; if (rise_cyc - start_cyc !== DET_LAT) begin failures++; $display("FAIL glitch_detect got=%0d exp=%0d", rise_cyc - start_cyc, DET_LAT); end
    checks++; if (fall_cyc - rise_cyc !== 8) begin failures++; $display("FAIL glitch_busy_len got=%0d exp=8", fall_cyc - rise_cyc); end
    checks++; if (dv_cnt - dv0 !== 0) begin failures++; $display("FAIL glitch_dv got=%0d exp=0", dv_cnt - dv0); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (byte_o !== 8'hFF) begin failures++; $display("FAIL glitch_byte_hold got=%h exp=ff", byte_o); end
  endtask

  task automatic test_frame_error;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(40);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_fe_count got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (dv_cnt - dv0 !== 0) begin failures++; $display("FAIL ferr_dv_count got=%0d exp=0", dv_cnt - dv0); end
    checks++; if (byte_o !== 8'h55) begin failures++; $display("FAIL ferr_byte got=%h exp=55", byte_o); end
  endtask

  task automatic test_mid_frame_reset;
    int dv0;
    logic [7:0] b;
    dv0 = dv_cnt;
    b = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx = 1'b1;
    checks++; if (byte_o !== 8'h00) begin failures++; $display("FAIL mreset_byte got=%h exp=00", byte_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mreset_busy got=%b exp=0", busy); end
    idle(40);
    send_frame(8'h42, 1'b1);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL mreset_dv_count got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (dv_bytes[dv0] !== 8'h42) begin failures++; $display("FAIL mreset_byte_42 got=%h exp=42", dv_bytes[dv0]); end
  endtask

  task automatic test_enable;
    int dv0, fe0;
    logic [7:0] b;
    dv0 = dv_cnt; fe0 = fe_cnt;
    b = 8'h0F;
    drive_bit(1'b0);
    drive_bit(b[0]);
    drive_bit(b[1]);
    rx = b[2];
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_busy_before got=%b exp=1", busy); end
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_idle_next_edge got=%b exp=0", busy); end
    idle(30);
    en = 1'b1;
    idle(5);
    send_frame(8'h0F, 1'b1);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL en_dv_count got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (dv_bytes[dv0] !== 8'h0F) begin failures++; $display("FAIL en_byte got=%h exp=0f", dv_bytes[dv0]); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL en_fe_count got=%0d exp=0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_mid_frame_reset;
    test_enable;
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL dv_fe_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
